uart_tx: RTL and testbench

- 8N1 UART transmitter driving the board's RsTx pin, the transmit counterpart to the RsRx receive path.
- Accepts bytes from the CPU/debug side over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte LSB-first at a fixed baud rate derived from the system clock.
- Instantiated in top; its tx output connects directly to RsTx.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 86 ++++++++
 rtl/uart_tx.sv | 165 ++++++++++++++++
 tb/tb_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the 8N1 UART transmit path: data
//                width, transmitter FSM state encoding and the baud divisor
//                helper used at elaboration time.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Whole system clocks per bit period (truncating division).
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Small synchronous FIFO buffering bytes ahead of the UART
//                serialiser. Read data is presented combinationally from the
//                head entry; a pop simply advances the read pointer.
//  Ports       : clk, reset    - clock, asynchronous active-high reset
//                push/push_data - write strobe and data (ignored when full)
//                pop/pop_data   - read strobe (ignored when empty), head data
//                count          - entries held, 0..DEPTH
//                full/empty     - status flags derived from count
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             push_ok,  pop_ok;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Pointers are exactly AW bits wide, so the +1 wraps modulo DEPTH for free.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 UART transmitter. Bytes arrive over a valid/ready
//                handshake into a small FIFO and are serialised LSB-first at
//                CLK_HZ/BAUD clocks per bit. Frames are sent back-to-back
//                when the FIFO has data at the end of a stop bit.
//  Ports       : clk, reset  - clock, asynchronous active-high reset
//                in_data     - byte to send, captured when in_valid && in_ready
//                in_valid    - in_data is valid this cycle
//                in_ready    - FIFO has room
//                tx          - registered serial line, idle high
//                busy        - frame in progress or bytes still buffered
//                fifo_count  - bytes currently buffered
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [UART_DATA_BITS-1:0]     in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int BCW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLK_HZ/BAUD must be at least 2");
  end

  uart_tx_state_t              state_q,    state_d;
  logic [BCW-1:0]              baud_cnt_q, baud_cnt_d;
  logic [2:0]                  bit_idx_q,  bit_idx_d;
  logic [UART_DATA_BITS-1:0]   shift_q,    shift_d;
  logic                        tx_q,       tx_d;

  logic                        baud_last;
  logic                        pop;
  logic                        push;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [UART_DATA_BITS-1:0]   fifo_data;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign baud_last = (baud_cnt_q == BAUD_LAST);
  // Popping on the final stop-bit cycle lets the next START follow with no gap.
  assign pop = !fifo_empty &&
               ((state_q == IDLE) || ((state_q == STOP) && baud_last));

  assign busy = (state_q != IDLE) || (fifo_count != '0);
  assign tx   = tx_q;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (pop) begin
          state_d = START;
          shift_d = fifo_data;
        end
      end
      START: begin
        if (baud_last) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
        end else begin
          baud_cnt_d = baud_cnt_q + BCW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BCW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (pop) begin
            state_d = START;
            shift_d = fifo_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BCW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  // The line level is registered from the current state, so tx trails the
  // state register by one cycle and stays glitch-free on the pin.
  always_comb begin
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx at CLK_HZ=1000, BAUD=100
//                (10 clocks per bit, 100 clocks per frame). A line-level
//                reference model predicts every cycle's outputs from the
//                push history; directed tables cover the corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: each accepted byte with its push edge and pop edge.
  int         m_push[$];
  int         m_pop[$];
  logic [7:0] m_data[$];
  int         last_pop = -1000000;

  typedef struct {
    int   off;
    logic tx;
    logic busy;
  } sb_t;

  typedef struct {
    logic       vld;
    logic [7:0] d;
    int         cycles;
    logic       e_tx;
    logic       e_ready;
    logic [2:0] e_cnt;
  } vec_t;

  sb_t  sb[12];
  vec_t vt[10];

  uart_tx #(
    .CLK_HZ     (1000),
    .BAUD       (100),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic int m_count(input int n);
    int c;
    c = 0;
    foreach (m_pop[i]) if (m_push[i] <= n && m_pop[i] > n) c++;
    return c;
  endfunction

  function automatic logic m_tx(input int n);
    int o;
    int b;
    foreach (m_pop[i]) begin
      o = n - m_pop[i] - 1;
      if (o >= 0 && o < FRAME) begin
        b = o / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_data[i][b-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic m_busy(input int n);
    foreach (m_pop[i]) if (m_pop[i] <= n && n < m_pop[i] + FRAME) return 1'b1;
    return m_count(n) != 0;
  endfunction

  function automatic void model_push(input logic [7:0] d, input int t);
    int p;
    p = (last_pop + FRAME > t + 1) ? last_pop + FRAME : t + 1;
    m_push.push_back(t);
    m_pop.push_back(p);
    m_data.push_back(d);
    last_pop = p;
  endfunction

  function automatic void model_clear();
    m_push.delete();
    m_pop.delete();
    m_data.delete();
    last_pop = -1000000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
  endtask

  task automatic check_model();
    chk("model_tx",         32'(tx),         32'(m_tx(cyc)));
    chk("model_busy",       32'(busy),       32'(m_busy(cyc)));
    chk("model_in_ready",   32'(in_ready),   32'(m_count(cyc) != DEPTH));
    chk("model_fifo_count", 32'(fifo_count), 32'(m_count(cyc)));
  endtask

  // One clock: drive inputs, take the edge, update the model, check 1 ns later.
  task automatic step(input logic v, input logic [7:0] d);
    logic acc;
    in_valid = v;
    in_data  = d;
    acc = v && (m_count(cyc) != DEPTH);
    @(posedge clk);
    cyc++;
    if (acc) model_push(d, cyc);
    #1;
    check_model();
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step(1'b0, 8'h00);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (m_busy(cyc) && k < 2000) begin
      step(1'b0, 8'h00);
      k++;
    end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  // Assert reset between edges and check outputs before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    chk({tag, "_tx"},       32'(tx),         32'd1);
    chk({tag, "_busy"},     32'(busy),       32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready),   32'd1);
    chk({tag, "_count"},    32'(fifo_count), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    cyc = 0;
  endtask

  initial begin
    int t0;
    int p;
    int mode;

    sb[0]  = '{1,   1'b1, 1'b1};
    sb[1]  = '{2,   1'b0, 1'b1};
    sb[2]  = '{11,  1'b0, 1'b1};
    sb[3]  = '{12,  1'b1, 1'b1};
    sb[4]  = '{21,  1'b1, 1'b1};
    sb[5]  = '{22,  1'b0, 1'b1};
    sb[6]  = '{32,  1'b1, 1'b1};
    sb[7]  = '{82,  1'b0, 1'b1};
    sb[8]  = '{92,  1'b1, 1'b1};
    sb[9]  = '{100, 1'b1, 1'b1};
    sb[10] = '{101, 1'b1, 1'b0};
    sb[11] = '{110, 1'b1, 1'b0};

    vt[0] = '{1'b1, 8'h01, 1,  1'b1, 1'b1, 3'd1};
    vt[1] = '{1'b1, 8'h02, 1,  1'b1, 1'b1, 3'd1};
    vt[2] = '{1'b1, 8'h03, 1,  1'b0, 1'b1, 3'd2};
    vt[3] = '{1'b1, 8'h04, 1,  1'b0, 1'b1, 3'd3};
    vt[4] = '{1'b1, 8'h05, 1,  1'b0, 1'b0, 3'd4};
    vt[5] = '{1'b1, 8'h06, 96, 1'b1, 1'b0, 3'd4};
    vt[6] = '{1'b1, 8'h06, 1,  1'b1, 1'b1, 3'd3};
    vt[7] = '{1'b1, 8'h06, 1,  1'b0, 1'b0, 3'd4};
    vt[8] = '{1'b0, 8'h00, 10, 1'b0, 1'b0, 3'd4};
    vt[9] = '{1'b0, 8'h00, 10, 1'b1, 1'b0, 3'd4};

    // Power-on reset, checked before the first clock edge.
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2;
    chk("por_tx",       32'(tx),         32'd1);
    chk("por_busy",     32'(busy),       32'd0);
    chk("por_in_ready", 32'(in_ready),   32'd1);
    chk("por_count",    32'(fifo_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    repeat (3) step(1'b0, 8'h00);

    // Single byte 0x55, hand-derived line samples relative to the push edge.
    t0 = cyc + 1;
    step(1'b1, 8'h55);
    for (int k = 0; k < 12; k++) begin
      run_to(t0 + sb[k].off);
      chk("single_tx",   32'(tx),   32'(sb[k].tx));
      chk("single_busy", 32'(busy), 32'(sb[k].busy));
    end
    drain();

    // 0x00 then 0xFF back-to-back: 90 low + 10 high, then 10 low + 90 high.
    t0 = cyc + 1;
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    run_to(t0 + 2);   chk("zero_start",  32'(tx), 32'd0);
    run_to(t0 + 91);  chk("zero_last",   32'(tx), 32'd0);
    run_to(t0 + 92);  chk("zero_stop",   32'(tx), 32'd1);
    run_to(t0 + 101); chk("zero_stop_e", 32'(tx), 32'd1);
    run_to(t0 + 102); chk("ff_start",    32'(tx), 32'd0);
    run_to(t0 + 111); chk("ff_start_e",  32'(tx), 32'd0);
    run_to(t0 + 112); chk("ff_data",     32'(tx), 32'd1);
    run_to(t0 + 200); chk("ff_busy",     32'(busy), 32'd1);
    run_to(t0 + 201); chk("ff_idle",     32'(busy), 32'd0);
    drain();

    // FIFO-full table: five held pushes, a sixth waiting for a free slot.
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < vt[r].cycles; c++) step(vt[r].vld, vt[r].d);
      chk("full_tx",    32'(tx),         32'(vt[r].e_tx));
      chk("full_ready", 32'(in_ready),   32'(vt[r].e_ready));
      chk("full_count", 32'(fifo_count), 32'(vt[r].e_cnt));
    end
    drain();

    // Push landing on the last STOP cycle while two bytes are queued.
    t0 = cyc + 1;
    p  = t0 + 1;
    step(1'b1, 8'hA1);
    step(1'b1, 8'hB2);
    step(1'b1, 8'hC3);
    run_to(p + 99);
    chk("simul_pre_count", 32'(fifo_count), 32'd2);
    step(1'b1, 8'hD4);
    chk("simul_count", 32'(fifo_count), 32'd2);
    chk("simul_stop",  32'(tx),         32'd1);
    step(1'b0, 8'h00);
    chk("simul_start", 32'(tx),         32'd0);
    drain();

    // Reset during bit 3 of 0xA5 with two bytes still queued.
    t0 = cyc + 1;
    p  = t0 + 1;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    run_to(p + 45);
    chk("midrst_pre_tx",    32'(tx),         32'd0);
    chk("midrst_pre_count", 32'(fifo_count), 32'd2);
    async_reset("midrst");
    repeat (250) step(1'b0, 8'h00);
    chk("midrst_post_count", 32'(fifo_count), 32'd0);
    chk("midrst_post_tx",    32'(tx),         32'd1);

    // Randomised traffic alternating sparse and bursty phases.
    for (int i = 0; i < 2400; i++) begin
      if (i % 300 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       step($urandom_range(0, 59) == 0, 8'($urandom));
        1:       step($urandom_range(0, 3) == 0,  8'($urandom));
        default: step($urandom_range(0, 149) == 0, 8'($urandom));
      endcase
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
